branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DW, default 32: operand, PC and target width; legal range 32..64.
REQ-002 Parameter BHT_DEPTH, default 64: predictor entries; power of two, minimum 4.
REQ-003 Parameter CNT_W, default 16: width of the statistics counters.
REQ-004 Port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-005 Port resetn, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid / in_ready, input / output, 1 each: request handshake.
REQ-007 Port in_op / in_rt, input, 6 / 5: MIPS opcode and rt field.
REQ-008 Port in_a / in_b / in_pc, input, DW each: rs value, rt value and branch PC.
REQ-009 Port in_imm16 / in_pred_taken, input, 16 / 1: offset and front-end prediction.
REQ-010 Port flush, input, 1: synchronous pipeline kill.
REQ-011 Port out_valid / out_ready, output / input, 1 each: result handshake.
REQ-012 Port out_is_branch / out_taken / out_mispredict / out_link_en, output, 1 each: result flags.
REQ-013 Port out_target / out_redirect_pc / out_link_addr, output, DW each: result addresses.
REQ-014 Port lk_pc / lk_taken, input DW / output 1: predictor lookup.
REQ-015 Port branch_cnt / mispredict_cnt, output, CNT_W each: statistics.

Function
REQ-016 Recognised branches SHALL be BEQ (a==b), BNE (a!=b), BGTZ (a signed >0), BLEZ (a[DW-1] OR a==0), and under REGIMM: BLTZ/BLTZAL (a[DW-1]) and BGEZ/BGEZAL (!a[DW-1]).
REQ-017 Any other op/rt SHALL produce out_is_branch=0, out_taken=0, out_mispredict=0, out_link_en=0, with no predictor or counter update.
REQ-018 in_ready SHALL equal (!out_valid OR out_ready) AND !flush.
REQ-019 An accepted request SHALL appear on the outputs exactly one cycle later; out_valid and all outputs SHALL hold stable while out_valid && !out_ready.
REQ-020 out_target SHALL be in_pc + 4 + (sign-extended in_imm16 << 2), modulo 2^DW.
REQ-021 out_link_addr SHALL be in_pc + 8 modulo 2^DW; out_link_en SHALL be 1 only for BLTZAL/BGEZAL, regardless of outcome.
REQ-022 out_redirect_pc SHALL be out_target when taken, else out_link_addr (delay-slot successor).
REQ-023 out_mispredict SHALL be out_is_branch AND (out_taken != in_pred_taken).
REQ-024 The BHT SHALL hold one 2-bit saturating counter per entry, indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-025 lk_taken SHALL be combinational: the MSB of the entry selected by lk_pc.
REQ-026 On each accepted branch, the indexed counter SHALL increment (taken) or decrement (not taken), saturating at 3 and 0.
REQ-027 A lookup in the same cycle as a write to the same entry SHALL return the pre-write value.
REQ-028 branch_cnt SHALL increment on every accepted branch; mispredict_cnt on every accepted mispredicted branch; both SHALL saturate at all-ones.
REQ-029 When flush=1, out_valid SHALL be 0 at the next edge and no request SHALL be accepted that cycle.
REQ-030 Flush SHALL not alter the BHT or the counters.

Reset
REQ-031 While resetn=0: out_valid=0, all other output registers 0, every BHT entry 2'b01 (weakly not-taken), both counters 0.
REQ-032 A reset asserted mid-transaction SHALL discard the held result; no partial state SHALL survive.

Structure
REQ-033 Opcode, REGIMM rt codes and ZeroWord SHALL come from the shared defines header; no local literals.
REQ-034 The predictor array and its saturating-update logic SHALL be a sub-module bht_2bit (parameters DEPTH, AW).
REQ-035 Comparison SHALL be combinational ahead of a single output register stage; no other pipeline stages.

Verification
REQ-036 BEQ a=5, b=5, pc=0x100, imm=0x0003, pred=0 -> next cycle taken=1, target=0x110, redirect=0x110, mispredict=1, branch_cnt=1.
REQ-037 BLEZ a=0 then a=0xFFFFFFFF then a=1 -> taken=1, 1, 0.
REQ-038 BGEZAL a=7, pc=0xFFFFFFF8, imm=0xFFFF -> taken=1, link_en=1, link_addr=0x00000000 (wrap), target=0xFFFFFFF8.
REQ-039 Four taken BNE at pc=0x40 -> lk_taken(0x40) reads 0, 1, 1, 1 after updates 0, 1, 2, 3; a fifth taken update leaves the counter at 3.
REQ-040 out_ready=0 for 3 cycles with a result held, then flush=1 with in_valid=1 -> outputs stable while stalled, out_valid=0 next cycle, request not accepted, counters unchanged.
REQ-041 resetn pulled low with out_valid=1 and a BHT entry at 3 -> out_valid=0, entry=1 and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared MIPS branch encodings and decode helper for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [63:0] ZERO_WORD = 64'h0;
  localparam logic [1:0]  BHT_INIT  = 2'b01;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_EQ,
    BR_NE,
    BR_GTZ,
    BR_LEZ,
    BR_LTZ,
    BR_GEZ
  } br_kind_e;

  typedef struct packed {
    br_kind_e kind;
    logic     link;
  } br_dec_t;

  function automatic br_dec_t decode_branch(input logic [5:0] op, input logic [4:0] rt);
    br_dec_t d;
    d.kind = BR_NONE;
    d.link = 1'b0;
    case (op)
      OP_BEQ:  d.kind = BR_EQ;
      OP_BNE:  d.kind = BR_NE;
      OP_BLEZ: d.kind = BR_LEZ;
      OP_BGTZ: d.kind = BR_GTZ;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   d.kind = BR_LTZ;
          RT_BGEZ:   d.kind = BR_GEZ;
          RT_BLTZAL: begin
            d.kind = BR_LTZ;
            d.link = 1'b1;
          end
          RT_BGEZAL: begin
            d.kind = BR_GEZ;
            d.link = 1'b1;
          end
          default: d.kind = BR_NONE;
        endcase
      end
      default: d.kind = BR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table of 2-bit saturating counters; lookup reads pre-write state.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] lk_idx,
  output logic          lk_taken,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic          wr_taken
);

  logic [1:0] cnt_q [DEPTH];
  logic [1:0] cur_c;
  logic [1:0] cnt_d;

  always_comb begin
    cur_c = cnt_q[wr_idx];
    cnt_d = cur_c;
    if (wr_taken && (cur_c != 2'b11)) begin
      cnt_d = cur_c + 2'b01;
    end else if (!wr_taken && (cur_c != 2'b00)) begin
      cnt_d = cur_c - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= BHT_INIT;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= cnt_d;
    end
  end

  assign lk_taken = cnt_q[lk_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// MIPS branch resolution: combinational compare, one output register stage,
// 2-bit BHT training and saturating branch/mispredict statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [4:0]       in_rt,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic [DW-1:0]    in_pc,
  input  logic [15:0]      in_imm16,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_branch,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_link_en,
  output logic [DW-1:0]    out_target,
  output logic [DW-1:0]    out_redirect_pc,
  output logic [DW-1:0]    out_link_addr,
  input  logic [DW-1:0]    lk_pc,
  output logic             lk_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int            AW   = $clog2(BHT_DEPTH);
  localparam logic [DW-1:0] ZERO = ZERO_WORD[DW-1:0];

  br_dec_t       dec_c;
  logic          is_branch_c, taken_c, mis_c;
  logic          a_neg, a_zero, eq_c;
  logic [DW-1:0] imm_ext, target_c, link_c;
  logic          accept, bht_wr;
  logic          unused_lk_pc;

  logic          valid_q, valid_d;
  logic          is_br_q, is_br_d;
  logic          taken_q, taken_d;
  logic          mis_q, mis_d;
  logic          link_en_q, link_en_d;
  logic [DW-1:0] target_q, target_d;
  logic [DW-1:0] redirect_q, redirect_d;
  logic [DW-1:0] link_addr_q, link_addr_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  assign dec_c  = decode_branch(in_op, in_rt);
  assign a_neg  = in_a[DW-1];
  assign a_zero = (in_a == ZERO);
  assign eq_c   = (in_a == in_b);

  always_comb begin
    taken_c = 1'b0;
    case (dec_c.kind)
      BR_EQ:   taken_c = eq_c;
      BR_NE:   taken_c = !eq_c;
      BR_GTZ:  taken_c = !a_neg && !a_zero;
      BR_LEZ:  taken_c = a_neg || a_zero;
      BR_LTZ:  taken_c = a_neg;
      BR_GEZ:  taken_c = !a_neg;
      default: taken_c = 1'b0;
    endcase
  end

  assign is_branch_c = (dec_c.kind != BR_NONE);
  assign mis_c       = is_branch_c && (taken_c != in_pred_taken);

  // Word offset: sign-extend the 16-bit immediate and scale by 4.
  assign imm_ext  = {{(DW-18){in_imm16[15]}}, in_imm16, 2'b00};
  assign target_c = in_pc + DW'(4) + imm_ext;
  assign link_c   = in_pc + DW'(8);

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign bht_wr   = accept && is_branch_c;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .AW    (AW)
  ) u_bht (
    .clk      (clk),
    .resetn   (resetn),
    .lk_idx   (lk_pc[AW+1:2]),
    .lk_taken (lk_taken),
    .wr_en    (bht_wr),
    .wr_idx   (in_pc[AW+1:2]),
    .wr_taken (taken_c)
  );

  assign unused_lk_pc = ^{lk_pc[DW-1:AW+2], lk_pc[1:0]};

  always_comb begin
    valid_d     = valid_q;
    is_br_d     = is_br_q;
    taken_d     = taken_q;
    mis_d       = mis_q;
    link_en_d   = link_en_q;
    target_d    = target_q;
    redirect_d  = redirect_q;
    link_addr_d = link_addr_q;
    br_cnt_d    = br_cnt_q;
    mis_cnt_d   = mis_cnt_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      is_br_d     = is_branch_c;
      taken_d     = taken_c;
      mis_d       = mis_c;
      link_en_d   = dec_c.link;
      target_d    = target_c;
      redirect_d  = taken_c ? target_c : link_c;
      link_addr_d = link_c;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    if (bht_wr && (br_cnt_q != {CNT_W{1'b1}})) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (bht_wr && mis_c && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q     <= 1'b0;
      is_br_q     <= 1'b0;
      taken_q     <= 1'b0;
      mis_q       <= 1'b0;
      link_en_q   <= 1'b0;
      target_q    <= ZERO;
      redirect_q  <= ZERO;
      link_addr_q <= ZERO;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      is_br_q     <= is_br_d;
      taken_q     <= taken_d;
      mis_q       <= mis_d;
      link_en_q   <= link_en_d;
      target_q    <= target_d;
      redirect_q  <= redirect_d;
      link_addr_q <= link_addr_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_is_branch   = is_br_q;
  assign out_taken       = taken_q;
  assign out_mispredict  = mis_q;
  assign out_link_en     = link_en_q;
  assign out_target      = target_q;
  assign out_redirect_pc = redirect_q;
  assign out_link_addr   = link_addr_q;
  assign branch_cnt      = br_cnt_q;
  assign mispredict_cnt  = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 8;

  logic          clk, resetn;
  logic          in_valid, in_ready;
  logic [5:0]    in_op;
  logic [4:0]    in_rt;
  logic [DW-1:0] in_a, in_b, in_pc;
  logic [15:0]   in_imm16;
  logic          in_pred_taken, flush;
  logic          out_valid, out_ready;
  logic          out_is_branch, out_taken, out_mispredict, out_link_en;
  logic [DW-1:0] out_target, out_redirect_pc, out_link_addr;
  logic [DW-1:0] lk_pc;
  logic          lk_taken;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  branch_resolve_unit #(.DW(DW), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rt(in_rt), .in_a(in_a), .in_b(in_b), .in_pc(in_pc),
    .in_imm16(in_imm16), .in_pred_taken(in_pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_is_branch(out_is_branch), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_link_en(out_link_en),
    .out_target(out_target), .out_redirect_pc(out_redirect_pc),
    .out_link_addr(out_link_addr),
    .lk_pc(lk_pc), .lk_taken(lk_taken),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit f_is_br(input logic [5:0] op, input logic [4:0] rt);
    if (op == OP_BEQ || op == OP_BNE || op == OP_BLEZ || op == OP_BGTZ) return 1'b1;
    if (op == OP_REGIMM && (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BLTZAL || rt == RT_BGEZAL))
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit f_taken(input logic [5:0] op, input logic [4:0] rt,
                                 input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = $signed(a);
    if (op == OP_BEQ)  return a == b;
    if (op == OP_BNE)  return a != b;
    if (op == OP_BLEZ) return sa <= 0;
    if (op == OP_BGTZ) return sa > 0;
    if (op == OP_REGIMM && (rt == RT_BLTZ || rt == RT_BLTZAL)) return sa < 0;
    if (op == OP_REGIMM && (rt == RT_BGEZ || rt == RT_BGEZAL)) return sa >= 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] f_target(input logic [31:0] pc, input logic [15:0] imm);
    longint t;
    t = longint'(pc) + 64'sd4 + 64'sd4 * longint'($signed(imm));
    return t[31:0];
  endfunction

  function automatic int f_idx(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  logic        m_valid, m_isb, m_taken, m_mis, m_link;
  logic [31:0] m_target, m_redir, m_laddr;
  int          m_bht [DEPTH];
  int          m_bcnt, m_mcnt;
  int          cnt_max;
  assign cnt_max = (1 << CW) - 1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0; m_isb <= 1'b0; m_taken <= 1'b0; m_mis <= 1'b0; m_link <= 1'b0;
      m_target <= '0; m_redir <= '0; m_laddr <= '0;
      for (int i = 0; i < DEPTH; i++) m_bht[i] <= 1;
      m_bcnt <= 0; m_mcnt <= 0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid  <= 1'b1;
      m_isb    <= f_is_br(in_op, in_rt);
      m_taken  <= f_is_br(in_op, in_rt) && f_taken(in_op, in_rt, in_a, in_b);
      m_mis    <= f_is_br(in_op, in_rt) && (f_taken(in_op, in_rt, in_a, in_b) != in_pred_taken);
      m_link   <= (in_op == OP_REGIMM) && (in_rt == RT_BLTZAL || in_rt == RT_BGEZAL);
      m_target <= f_target(in_pc, in_imm16);
      m_laddr  <= in_pc + 32'd8;
      m_redir  <= f_taken(in_op, in_rt, in_a, in_b) ? f_target(in_pc, in_imm16) : in_pc + 32'd8;
      if (f_is_br(in_op, in_rt)) begin
        if (f_taken(in_op, in_rt, in_a, in_b))
          m_bht[f_idx(in_pc)] <= (m_bht[f_idx(in_pc)] >= 3) ? 3 : m_bht[f_idx(in_pc)] + 1;
        else
          m_bht[f_idx(in_pc)] <= (m_bht[f_idx(in_pc)] <= 0) ? 0 : m_bht[f_idx(in_pc)] - 1;
        m_bcnt <= (m_bcnt >= cnt_max) ? cnt_max : m_bcnt + 1;
        if (f_taken(in_op, in_rt, in_a, in_b) != in_pred_taken)
          m_mcnt <= (m_mcnt >= cnt_max) ? cnt_max : m_mcnt + 1;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'((!m_valid || out_ready) && !flush));
    chk("lk_taken", 64'(lk_taken), 64'(m_bht[f_idx(lk_pc)] >= 2));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
    chk("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
    if (m_valid) begin
      chk("out_is_branch", 64'(out_is_branch), 64'(m_isb));
      chk("out_taken", 64'(out_taken), 64'(m_taken));
      chk("out_mispredict", 64'(out_mispredict), 64'(m_mis));
      chk("out_link_en", 64'(out_link_en), 64'(m_link));
      chk("out_target", 64'(out_target), 64'(m_target));
      chk("out_redirect_pc", 64'(out_redirect_pc), 64'(m_redir));
      chk("out_link_addr", 64'(out_link_addr), 64'(m_laddr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [15:0] imm,
                       input logic pred);
    in_valid = 1'b1; in_op = op; in_rt = rt; in_a = a; in_b = b; in_pc = pc;
    in_imm16 = imm; in_pred_taken = pred;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_rt = '0; in_a = '0; in_b = '0;
    in_pc = '0; in_imm16 = '0; in_pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b1;
    lk_pc = 32'h40;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_target", 64'(out_target), 64'h0);
    chk("rst_out_redirect", 64'(out_redirect_pc), 64'h0);
    chk("rst_out_link_addr", 64'(out_link_addr), 64'h0);
    chk("rst_out_taken", 64'(out_taken), 64'h0);
    chk("rst_branch_cnt", 64'(branch_cnt), 64'h0);
    chk("rst_lk_taken", 64'(lk_taken), 64'h0);
    resetn = 1'b1;
    tick();

    issue(OP_BEQ, 5'd0, 32'd5, 32'd5, 32'h100, 16'h0003, 1'b0);
    chk("beq_valid", 64'(out_valid), 64'h1);
    chk("beq_taken", 64'(out_taken), 64'h1);
    chk("beq_target", 64'(out_target), 64'h110);
    chk("beq_redirect", 64'(out_redirect_pc), 64'h110);
    chk("beq_mispredict", 64'(out_mispredict), 64'h1);
    chk("beq_branch_cnt", 64'(branch_cnt), 64'h1);

    issue(OP_BLEZ, 5'd0, 32'h0, 32'h0, 32'h200, 16'h0001, 1'b0);
    chk("blez_zero", 64'(out_taken), 64'h1);
    issue(OP_BLEZ, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h200, 16'h0001, 1'b0);
    chk("blez_neg", 64'(out_taken), 64'h1);
    issue(OP_BLEZ, 5'd0, 32'h1, 32'h0, 32'h200, 16'h0001, 1'b0);
    chk("blez_pos", 64'(out_taken), 64'h0);
    chk("blez_pos_redirect", 64'(out_redirect_pc), 64'h208);

    issue(6'h23, 5'd0, 32'h0, 32'h0, 32'h300, 16'h0004, 1'b1);
    chk("nonbr_is_branch", 64'(out_is_branch), 64'h0);
    chk("nonbr_mispredict", 64'(out_mispredict), 64'h0);
    chk("nonbr_branch_cnt", 64'(branch_cnt), 64'h4);

    issue(OP_REGIMM, RT_BGEZAL, 32'd7, 32'h0, 32'hFFFF_FFF8, 16'hFFFF, 1'b1);
    chk("bgezal_taken", 64'(out_taken), 64'h1);
    chk("bgezal_link_en", 64'(out_link_en), 64'h1);
    chk("bgezal_link_addr", 64'(out_link_addr), 64'h0);
    chk("bgezal_target", 64'(out_target), 64'hFFFF_FFF8);

    resetn = 1'b0;
    #1;
    chk("rst_pulse_cnt", 64'(branch_cnt), 64'h0);
    tick();
    resetn = 1'b1;
    tick();

    lk_pc = 32'h40;
    #1;
    chk("bht_init", 64'(lk_taken), 64'h0);
    for (int k = 1; k <= 5; k++) begin
      issue(OP_BNE, 5'd0, 32'd1, 32'd2, 32'h40, 16'h0000, 1'b1);
      chk($sformatf("bht_up%0d", k), 64'(lk_taken), 64'h1);
    end

    chk("async_pre_valid", 64'(out_valid), 64'h1);
    resetn = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'h0);
    chk("async_bht", 64'(lk_taken), 64'h0);
    chk("async_branch_cnt", 64'(branch_cnt), 64'h0);
    chk("async_mis_cnt", 64'(mispredict_cnt), 64'h0);
    tick();
    resetn = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) issue(OP_BNE, 5'd0, 32'd1, 32'd2, 32'h40, 16'h0000, 1'b1);
    issue(OP_BNE, 5'd0, 32'd3, 32'd3, 32'h40, 16'h0000, 1'b1);
    chk("bht_sat_dn1", 64'(lk_taken), 64'h1);
    issue(OP_BNE, 5'd0, 32'd3, 32'd3, 32'h40, 16'h0000, 1'b1);
    chk("bht_sat_dn2", 64'(lk_taken), 64'h0);
    lk_pc = 32'h44;
    #1;
    chk("bht_neighbour", 64'(lk_taken), 64'h0);

    tick();
    out_ready = 1'b0;
    issue(OP_BEQ, 5'd0, 32'd1, 32'd2, 32'h300, 16'hFFF0, 1'b1);
    chk("stall_target", 64'(out_target), 64'h2C4);
    chk("stall_mis_cnt", 64'(mispredict_cnt), 64'h3);
    in_valid = 1'b1; in_op = OP_BEQ; in_a = 32'd9; in_b = 32'd9; in_pc = 32'h500;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 64'(out_valid), 64'h1);
      chk("stall_redirect", 64'(out_redirect_pc), 64'h308);
      chk("stall_taken", 64'(out_taken), 64'h0);
      chk("stall_in_ready", 64'(in_ready), 64'h0);
    end
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_branch_cnt", 64'(branch_cnt), 64'h8);
    chk("flush_mis_cnt", 64'(mispredict_cnt), 64'h3);
    out_ready = 1'b1;
    tick();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 999) == 0) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0: begin in_op = OP_BEQ;  in_rt = 5'($urandom); end
        1: begin in_op = OP_BNE;  in_rt = 5'($urandom); end
        2: begin in_op = OP_BLEZ; in_rt = 5'($urandom); end
        3: begin in_op = OP_BGTZ; in_rt = 5'($urandom); end
        4: begin in_op = OP_REGIMM; in_rt = RT_BLTZ;   end
        5: begin in_op = OP_REGIMM; in_rt = RT_BGEZ;   end
        6: begin in_op = OP_REGIMM; in_rt = RT_BLTZAL; end
        7: begin in_op = OP_REGIMM; in_rt = RT_BGEZAL; end
        8: begin in_op = OP_REGIMM; in_rt = 5'($urandom); end
        default: begin in_op = 6'($urandom); in_rt = 5'($urandom); end
      endcase
      in_a = rnd_val();
      in_b = ($urandom_range(0, 2) == 0) ? in_a : rnd_val();
      in_pc = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31)) << 2;
      lk_pc = ($urandom_range(0, 1) == 0) ? in_pc : 32'($urandom);
      in_imm16 = 16'($urandom);
      in_pred_taken = 1'($urandom);
      tick();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
